ir_nec_frame_decoder: RTL and testbench

- Upstream front-end of the IR remote receiver interrupt wrapper: decodes the demodulated NEC stream from the IR receiver pin into 32-bit frames.
- Presents each decoded frame on a held data bus with a one-cycle ready pulse. The wrapper edge-detects that pulse to raise its IRQ.
- Also flags NEC repeat codes and malformed frames. Timing is measured in 1 µs ticks derived from the system clock.

---
 rtl/ir_nec_frame_decoder_if.sv | 33 +++
 rtl/ir_nec_frame_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_ir_nec_frame_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_frame_decoder_if.sv
// Output bundle of the NEC frame decoder. The demodulated IR input is also carried here
// so that one interface instance covers everything except clock and reset.
interface ir_nec_frame_decoder_if;
  logic        ir;
  logic [31:0] data;
  logic        data_ready;
  logic        cmd_ok;
  logic        repeat_pulse;
  logic        err_pulse;
  logic        busy;

  // Decoder side: consumes the IR pin and produces the frame outputs
  modport master (
    input  ir,
    output data,
    output data_ready,
    output cmd_ok,
    output repeat_pulse,
    output err_pulse,
    output busy
  );

  // Consumer side: the IRQ wrapper, or a bench that also drives the pin
  modport slave (
    output ir,
    input  data,
    input  data_ready,
    input  cmd_ok,
    input  repeat_pulse,
    input  err_pulse,
    input  busy
  );
endinterface

// File: rtl/ir_nec_frame_decoder.sv
// NEC IR frame decoder.
// The raw pin is synchronised and glitch filtered. Phase lengths are then measured in
// 1 us ticks between filtered edges, and each phase is checked against the NEC timing
// windows. A complete frame is presented on a held 32-bit bus with a one-cycle ready
// pulse. Repeat codes and malformed frames each produce their own one-cycle pulse.
module ir_nec_frame_decoder #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned GLITCH_CYC  = 100,
  parameter int unsigned TIMEOUT_US  = 12000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ir_nec_frame_decoder_if.master bus
);

  localparam int unsigned PRESC_TC = CLK_FREQ_HZ / 1000000 - 1;
  localparam int unsigned PRESC_W  = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;
  localparam int unsigned GLITCH_W = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC + 1) : 1;

  // Phase duration windows, in microseconds
  localparam logic [15:0] LEAD_LOW_MIN   = 16'd8000;
  localparam logic [15:0] LEAD_LOW_MAX   = 16'd10000;
  localparam logic [15:0] LEAD_SPACE_MIN = 16'd4000;
  localparam logic [15:0] LEAD_SPACE_MAX = 16'd5000;
  localparam logic [15:0] REP_SPACE_MIN  = 16'd1800;
  localparam logic [15:0] REP_SPACE_MAX  = 16'd2700;
  localparam logic [15:0] SHORT_MIN      = 16'd300;
  localparam logic [15:0] SHORT_MAX      = 16'd800;
  localparam logic [15:0] ONE_MIN        = 16'd1300;
  localparam logic [15:0] ONE_MAX        = 16'd2000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_LOW,
    S_LEAD_SPACE,
    S_BIT_BURST,
    S_BIT_SPACE,
    S_DATA_STOP,
    S_REP_STOP
  } state_t;

  logic [1:0]          sync_reg;
  logic                filt_reg;
  logic                filt_d_reg;
  logic [GLITCH_W-1:0] glitch_cnt_reg;
  logic [PRESC_W-1:0]  presc_reg;
  logic [15:0]         us_cnt_reg;
  state_t              state_reg;
  logic [4:0]          bit_idx_reg;
  logic [31:0]         shift_reg;
  logic [31:0]         data_reg;
  logic                cmd_ok_reg;
  logic                have_frame_reg;
  logic                ready_reg;
  logic                rep_reg;
  logic                err_reg;

  logic tick;
  logic fall_edge;
  logic rise_edge;
  logic any_edge;
  logic timed_out;

  function automatic logic in_win(input logic [15:0] d, input logic [15:0] lo,
                                  input logic [15:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  assign tick      = (presc_reg == PRESC_W'(PRESC_TC));
  assign fall_edge = filt_d_reg & ~filt_reg;
  assign rise_edge = ~filt_d_reg & filt_reg;
  assign any_edge  = fall_edge | rise_edge;
  assign timed_out = ({16'd0, us_cnt_reg} > TIMEOUT_US);

  // Two-flop synchroniser for the asynchronous IR pin (idle level is high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_reg <= 2'b11;
    else          sync_reg <= {sync_reg[0], bus.ir};
  end

  // Glitch filter: the level flips only after GLITCH_CYC consecutive differing samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg       <= 1'b1;
      glitch_cnt_reg <= '0;
    end else if (sync_reg[1] == filt_reg) begin
      glitch_cnt_reg <= '0;
    end else if (glitch_cnt_reg == GLITCH_W'(GLITCH_CYC - 1)) begin
      filt_reg       <= sync_reg[1];
      glitch_cnt_reg <= '0;
    end else begin
      glitch_cnt_reg <= glitch_cnt_reg + GLITCH_W'(1);
    end
  end

  // Delayed copy of the filtered level for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) filt_d_reg <= 1'b1;
    else          filt_d_reg <= filt_reg;
  end

  // Prescaler producing one tick per microsecond
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc_reg <= '0;
    else if (tick) presc_reg <= '0;
    else           presc_reg <= presc_reg + PRESC_W'(1);
  end

  // Phase length counter: saturating, restarts on every filtered edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            us_cnt_reg <= '0;
    else if (any_edge)                       us_cnt_reg <= '0;
    else if (tick && us_cnt_reg != 16'hFFFF) us_cnt_reg <= us_cnt_reg + 16'd1;
  end

  // Frame state machine: checks each completed phase and drives the registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      cmd_ok_reg     <= 1'b0;
      have_frame_reg <= 1'b0;
      ready_reg      <= 1'b0;
      rep_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      rep_reg   <= 1'b0;
      err_reg   <= 1'b0;
      if (any_edge) begin
        unique case (state_reg)
          S_IDLE: begin
            // A rising edge here is the tail of an aborted frame and is ignored
            if (fall_edge) state_reg <= S_LEAD_LOW;
          end
          S_LEAD_LOW: begin
            if (in_win(us_cnt_reg, LEAD_LOW_MIN, LEAD_LOW_MAX)) begin
              state_reg <= S_LEAD_SPACE;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= S_IDLE;
            end
          end
          S_LEAD_SPACE: begin
            if (in_win(us_cnt_reg, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
              bit_idx_reg <= '0;
              state_reg   <= S_BIT_BURST;
            end else if (in_win(us_cnt_reg, REP_SPACE_MIN, REP_SPACE_MAX)) begin
              state_reg <= S_REP_STOP;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= S_IDLE;
            end
          end
          S_BIT_BURST: begin
            if (in_win(us_cnt_reg, SHORT_MIN, SHORT_MAX)) begin
              state_reg <= S_BIT_SPACE;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= S_IDLE;
            end
          end
          S_BIT_SPACE: begin
            // The space length encodes the bit value; bits arrive LSB first
            if (in_win(us_cnt_reg, SHORT_MIN, SHORT_MAX) ||
                in_win(us_cnt_reg, ONE_MIN, ONE_MAX)) begin
              shift_reg[bit_idx_reg] <= in_win(us_cnt_reg, ONE_MIN, ONE_MAX);
              if (bit_idx_reg == 5'd31) begin
                state_reg <= S_DATA_STOP;
              end else begin
                bit_idx_reg <= bit_idx_reg + 5'd1;
                state_reg   <= S_BIT_BURST;
              end
            end else begin
              err_reg   <= 1'b1;
              state_reg <= S_IDLE;
            end
          end
          S_DATA_STOP: begin
            // Only a complete frame with a valid stop burst is published
            if (in_win(us_cnt_reg, SHORT_MIN, SHORT_MAX)) begin
              data_reg       <= shift_reg;
              cmd_ok_reg     <= (shift_reg[31:24] == ~shift_reg[23:16]);
              ready_reg      <= 1'b1;
              have_frame_reg <= 1'b1;
            end else begin
              err_reg <= 1'b1;
            end
            state_reg <= S_IDLE;
          end
          S_REP_STOP: begin
            // A repeat is only meaningful once a frame has been received
            if (in_win(us_cnt_reg, SHORT_MIN, SHORT_MAX)) begin
              rep_reg <= have_frame_reg;
            end else begin
              err_reg <= 1'b1;
            end
            state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end else if (state_reg != S_IDLE && timed_out) begin
        err_reg   <= 1'b1;
        state_reg <= S_IDLE;
      end
    end
  end

  assign bus.data         = data_reg;
  assign bus.cmd_ok       = cmd_ok_reg;
  assign bus.data_ready   = ready_reg;
  assign bus.repeat_pulse = rep_reg;
  assign bus.err_pulse    = err_reg;
  assign bus.busy         = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ir_nec_frame_decoder.sv
// Randomised bench for the NEC frame decoder. The clock runs at 1 MHz so that one
// cycle equals one microsecond tick. Expected outcomes come from a transaction-level
// model: what a well-formed frame or repeat should yield, given the frames already seen.
module tb_ir_nec_frame_decoder;
  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned GLITCH = 8;
  localparam int unsigned TMO_US = 12000;

  logic clk = 1'b0;
  logic reset_n;
  ir_nec_frame_decoder_if bus ();

  ir_nec_frame_decoder #(
    .CLK_FREQ_HZ(CLK_HZ),
    .GLITCH_CYC (GLITCH),
    .TIMEOUT_US (TMO_US)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge
  int cyc = 0;
  int ready_cnt = 0, rep_cnt = 0, err_cnt = 0, multi_cnt = 0;
  int err_cyc = 0;
  logic [31:0] ready_data;
  always @(negedge clk) begin
    cyc++;
    if (bus.data_ready) begin
      ready_cnt++;
      ready_data = bus.data;
    end
    if (bus.repeat_pulse) rep_cnt++;
    if (bus.err_pulse) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (int'(bus.data_ready) + int'(bus.repeat_pulse) + int'(bus.err_pulse) > 1) multi_cnt++;
  end

  // Reference state: what the receiver should be holding
  logic [31:0] exp_data;
  logic        exp_ok;
  bit          exp_have;
  bit          glitch_en = 0;
  bit          nominal   = 0;
  int ready_base, rep_base, err_base;
  int txn = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int jit(input int nom, input int j);
    if (nominal) return nom;
    return nom - j + int'($urandom_range(2 * j, 0));
  endfunction

  // Hold the pin at lvl for 'us' microseconds; optionally a 1 us low glitch in a high phase
  task automatic drive(input logic lvl, input int us);
    int g;
    g = (glitch_en && lvl && us > 40) ? int'($urandom_range(us - 20, 10)) : -1;
    for (int i = 0; i < us; i++) begin
      @(negedge clk);
      bus.ir = (i == g) ? 1'b0 : lvl;
    end
  endtask

  task automatic begin_txn();
    ready_base = ready_cnt;
    rep_base   = rep_cnt;
    err_base   = err_cnt;
  endtask

  task automatic end_txn(input string name, input int e_ready, input int e_rep, input int e_err);
    drive(1'b1, 1500);
    txn++;
    $display("txn %0d %-12s data=%08h cmd_ok=%0d ready=%0d rep=%0d err=%0d", txn, name,
             bus.data, bus.cmd_ok, ready_cnt - ready_base, rep_cnt - rep_base,
             err_cnt - err_base);
    check_eq({name, ".ready"}, 32'(ready_cnt - ready_base), 32'(e_ready));
    check_eq({name, ".repeat"}, 32'(rep_cnt - rep_base), 32'(e_rep));
    check_eq({name, ".err"}, 32'(err_cnt - err_base), 32'(e_err));
    check_eq({name, ".data"}, bus.data, exp_data);
    check_eq({name, ".cmd_ok"}, 32'(bus.cmd_ok), 32'(exp_ok));
    check_eq({name, ".busy"}, 32'(bus.busy), 32'd0);
    if (e_ready > 0) check_eq({name, ".ready_data"}, ready_data, exp_data);
  endtask

  // One NEC frame; stretch >= 0 makes that bit's space an illegal 1000 us and ends the burst
  task automatic send_frame(input string name, input logic [31:0] word, input int stretch);
    begin_txn();
    drive(1'b0, jit(9000, 300));
    drive(1'b1, jit(4500, 200));
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, jit(562, 100));
      if (i == stretch) begin
        drive(1'b1, 1000);
        drive(1'b0, jit(562, 100));
        break;
      end
      drive(1'b1, word[i] ? jit(1687, 150) : jit(562, 100));
    end
    if (stretch < 0) begin
      drive(1'b0, jit(562, 100));
      exp_data = word;
      exp_ok   = (word[31:24] == ~word[23:16]);
      exp_have = 1;
      end_txn(name, 1, 0, 0);
    end else begin
      end_txn(name, 0, 0, 1);
    end
  endtask

  task automatic send_repeat(input string name);
    begin_txn();
    drive(1'b0, jit(9000, 300));
    drive(1'b1, jit(2250, 150));
    drive(1'b0, jit(562, 100));
    end_txn(name, 0, exp_have ? 1 : 0, 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0] a, c;
    a = 8'($urandom);
    c = 8'($urandom);
    if ($urandom_range(1, 0) == 1) return {~c, c, ~a, a};
    return $urandom;
  endfunction

  initial begin
    int fall_at;
    bus.ir   = 1'b1;
    reset_n  = 1'b0;
    exp_data = '0;
    exp_ok   = 1'b0;
    exp_have = 0;
    repeat (5) @(negedge clk);
    check_eq("reset.data", bus.data, 32'd0);
    check_eq("reset.flags", {27'd0, bus.cmd_ok, bus.data_ready, bus.repeat_pulse,
                             bus.err_pulse, bus.busy}, 32'd0);
    reset_n = 1'b1;
    drive(1'b1, 200);

    // Exact nominal timings first
    nominal = 1;
    send_repeat("rep_no_frame");
    send_frame("std_frame", 32'hBA45FF00, -1);
    send_repeat("repeat");
    send_frame("bad_compl", 32'h0045FF00, -1);
    nominal = 0;

    // Stretched bit 10 space, then a clean frame
    send_frame("stretch_b10", rand_word(), 10);
    send_frame("after_err", rand_word(), -1);

    // Lead burst held low for 15 ms
    begin_txn();
    fall_at = cyc;
    drive(1'b0, 15000);
    check_eq("timeout.late", 32'((err_cyc - fall_at) <= int'(TMO_US + GLITCH + 10)), 32'd1);
    check_eq("timeout.early", 32'((err_cyc - fall_at) >= int'(TMO_US)), 32'd1);
    end_txn("timeout", 0, 0, 1);

    // Random traffic with 1 us glitches in idle and spaces
    glitch_en = 1;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(2, 0))
        0:       send_frame("rnd_frame", rand_word(), -1);
        1:       send_repeat("rnd_repeat");
        default: send_frame("rnd_abort", rand_word(), int'($urandom_range(31, 0)));
      endcase
    end
    send_frame("glitch_frame", 32'hBA45FF00, -1);
    glitch_en = 0;

    // Reset in the middle of a frame
    begin_txn();
    drive(1'b0, 9000);
    drive(1'b1, 4500);
    drive(1'b0, 562);
    drive(1'b1, 1687);
    drive(1'b0, 300);
    reset_n = 1'b0;
    bus.ir  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst.data", bus.data, 32'd0);
    check_eq("midrst.flags", {27'd0, bus.cmd_ok, bus.data_ready, bus.repeat_pulse,
                              bus.err_pulse, bus.busy}, 32'd0);
    reset_n  = 1'b1;
    exp_data = '0;
    exp_ok   = 1'b0;
    exp_have = 0;
    end_txn("mid_reset", 0, 0, 0);
    send_repeat("rep_after_rst");

    check_eq("pulse_excl", 32'(multi_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
